viterbi_traceback: RTL and testbench

Frame-based survivor-path manager and traceback engine for the Viterbi decoder, K=5 (16 states). It accepts one 16-bit ACS decision vector per trellis step and writes it into the external 24x2048 survivor SRAM. When the frame ends, it reads the SRAM backwards from the last step and emits one decoded bit per cycle, each tagged with its step index. It sits between the ACS array (upstream) and the survivor SRAM, and feeds the output bit packer (downstream).

---
 rtl/viterbi_pkg.sv | 25 ++
 rtl/viterbi_traceback.sv | 146 ++++++++++++++
 tb/tb_viterbi_traceback.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared Viterbi K=5 constants, types and trellis helpers
package viterbi_pkg;

  localparam int K          = 5;
  localparam int STATE_W    = K - 1;
  localparam int NUM_STATES = 1 << STATE_W;
  localparam int SRAM_AW    = 11;
  localparam int SRAM_DW    = 24;

  typedef logic [STATE_W-1:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_TB    = 2'd2,
    ST_DRAIN = 2'd3
  } tb_fsm_t;

  // Predecessor of state s given its survivor decision d: the oldest input
  // falls out of the LSB side going forward, so stepping back shifts it in.
  function automatic state_t tb_pred(input state_t s, input logic d);
    return {s[STATE_W-2:0], d};
  endfunction

endpackage

// File: rtl/viterbi_traceback.sv
// rtl/viterbi_traceback.sv - survivor SRAM writer and backward traceback engine
module viterbi_traceback
  import viterbi_pkg::*;
#(
  parameter int MAX_STEPS = 2048
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               acs_valid_i,
  output logic               acs_ready_o,
  input  logic [15:0]        acs_dec_i,
  input  logic               acs_last_i,
  input  logic [3:0]         acs_start_i,
  output logic               sram_wr_en_o,
  output logic               sram_rd_en_o,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [SRAM_DW-1:0] sram_wdata_o,
  input  logic [SRAM_DW-1:0] sram_rdata_i,
  output logic               dec_valid_o,
  output logic               dec_bit_o,
  output logic [SRAM_AW-1:0] dec_idx_o,
  output logic               frame_done_o,
  output logic               ovf_o
);

  tb_fsm_t            state_q, state_d;
  logic [SRAM_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [SRAM_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [SRAM_AW-1:0] raddr_q;
  logic               rvalid_q;
  state_t             trace_s_q, trace_s_d;

  logic               ready_d, wr_en_d, rd_en_d, dec_valid_d, dec_bit_d;
  logic               frame_done_d, ovf_d;
  logic [SRAM_AW-1:0] addr_d, dec_idx_d;
  logic [SRAM_DW-1:0] wdata_d;

  logic accept, at_end, last_eff, surv_d;

  assign accept   = acs_valid_i & acs_ready_o;
  assign at_end   = (wr_ptr_q == SRAM_AW'(MAX_STEPS - 1));
  // A full SRAM closes the frame even without a last marker.
  assign last_eff = acs_last_i | at_end;
  // Decision bit of the current traceback state in the returned word.
  assign surv_d   = sram_rdata_i[{1'b0, trace_s_q}];

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = last_eff ? ST_TB : ST_FILL;
      ST_FILL:  if (accept && last_eff) state_d = ST_TB;
      ST_TB:    if (rd_ptr_q == '0) state_d = ST_DRAIN;
      ST_DRAIN: if (frame_done_o) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // FSM outputs and datapath next-state: write path, read issue, word processing
  always_comb begin
    ready_d      = (state_d == ST_IDLE) || (state_d == ST_FILL);
    wr_en_d      = 1'b0;
    rd_en_d      = 1'b0;
    addr_d       = sram_addr_o;
    wdata_d      = sram_wdata_o;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    trace_s_d    = trace_s_q;
    dec_valid_d  = 1'b0;
    dec_bit_d    = dec_bit_o;
    dec_idx_d    = dec_idx_o;
    frame_done_d = 1'b0;
    ovf_d        = ovf_o | (accept & at_end & ~acs_last_i);

    if (accept) begin
      wr_en_d = 1'b1;
      addr_d  = wr_ptr_q;
      wdata_d = {8'h00, acs_dec_i};
      if (last_eff) begin
        wr_ptr_d  = '0;
        rd_ptr_d  = wr_ptr_q;
        trace_s_d = acs_last_i ? state_t'(acs_start_i) : '0;
      end else begin
        wr_ptr_d = wr_ptr_q + SRAM_AW'(1);
      end
    end

    if (state_q == ST_TB) begin
      rd_en_d  = 1'b1;
      addr_d   = rd_ptr_q;
      rd_ptr_d = rd_ptr_q - SRAM_AW'(1);
    end

    if (rvalid_q) begin
      dec_valid_d  = 1'b1;
      dec_bit_d    = trace_s_q[STATE_W-1];
      dec_idx_d    = raddr_q;
      trace_s_d    = tb_pred(trace_s_q, surv_d);
      frame_done_d = (raddr_q == '0);
    end
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acs_ready_o  <= 1'b0;
      sram_wr_en_o <= 1'b0;
      sram_rd_en_o <= 1'b0;
      sram_addr_o  <= '0;
      sram_wdata_o <= '0;
      dec_valid_o  <= 1'b0;
      dec_bit_o    <= 1'b0;
      dec_idx_o    <= '0;
      frame_done_o <= 1'b0;
      ovf_o        <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      trace_s_q    <= '0;
      rvalid_q     <= 1'b0;
      raddr_q      <= '0;
    end else begin
      acs_ready_o  <= ready_d;
      sram_wr_en_o <= wr_en_d;
      sram_rd_en_o <= rd_en_d;
      sram_addr_o  <= addr_d;
      sram_wdata_o <= wdata_d;
      dec_valid_o  <= dec_valid_d;
      dec_bit_o    <= dec_bit_d;
      dec_idx_o    <= dec_idx_d;
      frame_done_o <= frame_done_d;
      ovf_o        <= ovf_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      trace_s_q    <= trace_s_d;
      rvalid_q     <= sram_rd_en_o;
      raddr_q      <= sram_rd_en_o ? sram_addr_o : raddr_q;
    end
  end

endmodule

// File: tb/tb_viterbi_traceback.sv
// tb/tb_viterbi_traceback.sv - self-checking bench for viterbi_traceback
module tb_viterbi_traceback;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        acs_valid = 1'b0;
  logic        acs_ready;
  logic [15:0] acs_dec = '0;
  logic        acs_last = 1'b0;
  logic [3:0]  acs_start = '0;
  logic        sram_wr_en, sram_rd_en;
  logic [10:0] sram_addr;
  logic [23:0] sram_wdata;
  logic [23:0] sram_rdata = '0;
  logic        dec_valid, dec_bit, frame_done, ovf;
  logic [10:0] dec_idx;

  viterbi_traceback #(.MAX_STEPS(2048)) dut (
    .clk_i(clk), .rst_i(rst),
    .acs_valid_i(acs_valid), .acs_ready_o(acs_ready), .acs_dec_i(acs_dec),
    .acs_last_i(acs_last), .acs_start_i(acs_start),
    .sram_wr_en_o(sram_wr_en), .sram_rd_en_o(sram_rd_en), .sram_addr_o(sram_addr),
    .sram_wdata_o(sram_wdata), .sram_rdata_i(sram_rdata),
    .dec_valid_o(dec_valid), .dec_bit_o(dec_bit), .dec_idx_o(dec_idx),
    .frame_done_o(frame_done), .ovf_o(ovf)
  );

  always #5 clk = ~clk;

  // Survivor SRAM: synchronous write, read data the cycle after the strobe.
  logic [23:0] mem [0:2047];
  always @(posedge clk) begin
    if (sram_wr_en) mem[sram_addr] <= sram_wdata;
    if (sram_rd_en) sram_rdata <= mem[sram_addr];
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled 1 time unit after each rising edge.
  int  cyc = 0;
  int  first_cyc = -1, fd_cyc = -1, rise_cyc = -1, fd_cnt = 0;
  int  hi_err = 0, ovl_err = 0;
  logic ready_prev = 1'b0;
  int  dq_idx[$];
  bit  dq_bit[$];
  bit  dq_fd[$];
  int  wa_q[$];
  int  ra_q[$];

  always @(posedge clk) begin
    #1;
    cyc++;
    if (dec_valid) begin
      if (dq_bit.size() == 0) first_cyc = cyc;
      dq_idx.push_back(int'(dec_idx));
      dq_bit.push_back(dec_bit);
      dq_fd.push_back(frame_done);
    end
    if (frame_done) begin
      fd_cyc = cyc;
      fd_cnt++;
    end
    if (acs_ready && !ready_prev && rise_cyc < 0) rise_cyc = cyc;
    ready_prev = acs_ready;
    if (sram_wr_en) begin
      wa_q.push_back(int'(sram_addr));
      if (sram_wdata[23:16] != 8'h00) hi_err++;
    end
    if (sram_rd_en) ra_q.push_back(int'(sram_addr));
    if (sram_wr_en && sram_rd_en) ovl_err++;
  end

  logic [15:0] stim [0:2047];
  bit          exp_bit [0:2047];
  bit          ovf_exp = 1'b0;

  // Reference traceback: walk the stored decisions from the newest step back.
  task automatic model(input int len, input logic [3:0] st);
    int s;
    int d;
    s = int'(st);
    for (int i = len - 1; i >= 0; i--) begin
      exp_bit[i] = ((s >> 3) & 1) != 0;
      d = (int'(stim[i]) >> s) & 1;
      s = ((s << 1) & 15) | d;
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_ready"},  {31'd0, acs_ready},  32'd0);
    check({pfx, "_wr_en"},  {31'd0, sram_wr_en}, 32'd0);
    check({pfx, "_rd_en"},  {31'd0, sram_rd_en}, 32'd0);
    check({pfx, "_addr"},   {21'd0, sram_addr},  32'd0);
    check({pfx, "_wdata"},  {8'd0, sram_wdata},  32'd0);
    check({pfx, "_dvalid"}, {31'd0, dec_valid},  32'd0);
    check({pfx, "_dbit"},   {31'd0, dec_bit},    32'd0);
    check({pfx, "_didx"},   {21'd0, dec_idx},    32'd0);
    check({pfx, "_fdone"},  {31'd0, frame_done}, 32'd0);
    check({pfx, "_ovf"},    {31'd0, ovf},        32'd0);
  endtask

  // Drive one frame of stim[0..len-1] and check the whole traceback.
  // abort_at > 0 returns early once that many bits have come out.
  task automatic run_frame(input int len, input bit use_last, input logic [3:0] st,
                           input bit hold, input int abort_at);
    int T;
    int n;
    int k;
    int nb;
    logic [3:0] eff_st;
    n = len - 1;
    eff_st = use_last ? st : 4'h0;
    model(len, eff_st);
    k = 0;
    while (!acs_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_frame", {31'd0, acs_ready}, 32'd1);
    dq_idx.delete(); dq_bit.delete(); dq_fd.delete(); wa_q.delete(); ra_q.delete();
    first_cyc = -1; fd_cyc = -1; rise_cyc = -1; fd_cnt = 0; hi_err = 0; ovl_err = 0;
    T = 0;
    for (int i = 0; i < len; i++) begin
      acs_valid = 1'b1;
      acs_dec   = stim[i];
      acs_last  = use_last && (i == len - 1);
      acs_start = acs_last ? st : 4'($urandom);
      if (!acs_ready) check("ready_during_fill", {31'd0, acs_ready}, 32'd1);
      T = cyc;
      @(negedge clk);
    end
    acs_valid = hold;
    acs_dec   = 16'($urandom);
    acs_last  = 1'b0;
    acs_start = 4'($urandom);
    if (!use_last) ovf_exp = 1'b1;
    k = 0;
    if (abort_at > 0) begin
      while (dq_bit.size() < abort_at && k < len + 40) begin
        @(negedge clk);
        k++;
      end
      check("abort_reached", {31'd0, dq_bit.size() >= abort_at}, 32'd1);
      return;
    end
    while (rise_cyc < 0 && k < len + 40) begin
      @(negedge clk);
      k++;
    end
    check("frame_timeout", {31'd0, rise_cyc >= 0}, 32'd1);
    check("bit_count", 32'(dq_bit.size()), 32'(len));
    nb = (dq_bit.size() < len) ? dq_bit.size() : len;
    for (int j = 0; j < nb; j++) begin
      check("dec_idx", 32'(dq_idx[j]), 32'(n - j));
      check("dec_bit", {31'd0, dq_bit[j]}, {31'd0, exp_bit[n - j]});
      check("fd_flag", {31'd0, dq_fd[j]}, {31'd0, j == n});
    end
    check("first_bit_cycle", 32'(first_cyc), 32'(T + 4));
    check("frame_done_cycle", 32'(fd_cyc), 32'(T + 4 + n));
    check("frame_done_count", 32'(fd_cnt), 32'd1);
    check("ready_rise_cycle", 32'(rise_cyc), 32'(T + 5 + n));
    check("write_count", 32'(wa_q.size()), 32'(len));
    for (int j = 0; j < wa_q.size() && j < len; j++)
      if (wa_q[j] != j) check("write_addr", 32'(wa_q[j]), 32'(j));
    check("read_count", 32'(ra_q.size()), 32'(len));
    for (int j = 0; j < ra_q.size() && j < len; j++)
      if (ra_q[j] != n - j) check("read_addr", 32'(ra_q[j]), 32'(n - j));
    check("wdata_pad", 32'(hi_err), 32'd0);
    check("wr_rd_overlap", 32'(ovl_err), 32'd0);
    check("ovf", {31'd0, ovf}, {31'd0, ovf_exp});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("rst0");
    rst = 1'b0;

    // 8 all-zero steps, start 0
    for (int i = 0; i < 8; i++) stim[i] = 16'h0000;
    run_frame(8, 1'b1, 4'h0, 1'b0, 0);

    // 3 directed steps, start 8: bits idx2..0 = 1,0,0
    stim[0] = 16'h0000; stim[1] = 16'h0001; stim[2] = 16'h0001;
    run_frame(3, 1'b1, 4'h8, 1'b0, 0);
    check("directed_bit_idx2", {31'd0, exp_bit[2]}, 32'd1);

    // single-step frame, bit = start[3]
    stim[0] = 16'($urandom);
    run_frame(1, 1'b1, 4'hA, 1'b0, 0);

    // random frames
    for (int f = 0; f < 4; f++) begin
      int len;
      len = int'($urandom_range(2, 40));
      for (int i = 0; i < len; i++) stim[i] = 16'($urandom);
      run_frame(len, 1'b1, 4'($urandom), 1'b0, 0);
    end

    // valid held through traceback, then next frame back to back
    for (int i = 0; i < 6; i++) stim[i] = 16'($urandom);
    run_frame(6, 1'b1, 4'($urandom), 1'b1, 0);
    for (int i = 0; i < 5; i++) stim[i] = 16'($urandom);
    run_frame(5, 1'b1, 4'($urandom), 1'b0, 0);

    // overflow: 2048 beats with no last marker
    for (int i = 0; i < 2048; i++) stim[i] = 16'($urandom);
    run_frame(2048, 1'b0, 4'hF, 1'b0, 0);

    // reset during traceback of a 10-step frame after 5 bits
    for (int i = 0; i < 10; i++) stim[i] = 16'($urandom);
    run_frame(10, 1'b1, 4'($urandom), 1'b0, 5);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    ovf_exp = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) stim[i] = 16'($urandom);
    run_frame(4, 1'b1, 4'($urandom), 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
